// File: rtl/frame_update_sequencer_pkg.sv
// rtl/frame_update_sequencer_pkg.sv - shared constants and types for the frame update sequencer
package frame_update_sequencer_pkg;

    localparam int SEQ_NUM_STAGES    = 4;

    localparam int SEQ_STAGE_INPUT   = 0;
    localparam int SEQ_STAGE_MOVE    = 1;
    localparam int SEQ_STAGE_COLLIDE = 2;
    localparam int SEQ_STAGE_SCORE   = 3;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_START = 2'd1,
        SEQ_WAIT  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/frame_update_sequencer_stage_watchdog.sv
// rtl/frame_update_sequencer_stage_watchdog.sv - per-stage saturating wait timer
module stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int              CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    // Saturates at the last count so a stalled stage keeps reporting expiry.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/frame_update_sequencer.sv
// rtl/frame_update_sequencer.sv - runs one ordered start/done pass over the update stages per frame
module frame_update_sequencer
    import frame_update_sequencer_pkg::*;
#(
    parameter int NUM_STAGES      = SEQ_NUM_STAGES,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int FRAME_CNT_WIDTH = 16,
    localparam int IDX_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic                       enable,
    input  logic [NUM_STAGES-1:0]      stage_done,
    output logic [NUM_STAGES-1:0]      stage_start,
    output logic [IDX_W-1:0]           current_stage,
    output logic                       busy,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       overrun,
    output logic                       timeout_err
);

    seq_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_STAGES-1:0]      stage_start_q, stage_start_d;
    logic [IDX_W-1:0]           current_stage_q, current_stage_d;
    logic                       busy_q, busy_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
    logic                       overrun_q, overrun_d;
    logic                       timeout_err_q, timeout_err_d;

    logic wd_expired;
    logic done_cur;
    logic last_stage;

    assign done_cur   = stage_done[idx_q];
    assign last_stage = (idx_q == IDX_W'(NUM_STAGES - 1));

    stage_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .resetN  (resetN),
        .clear   (state_q == SEQ_START),
        .run     (state_q == SEQ_WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q         <= SEQ_IDLE;
            idx_q           <= '0;
            stage_start_q   <= '0;
            current_stage_q <= '0;
            busy_q          <= 1'b0;
            frame_count_q   <= '0;
            overrun_q       <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            stage_start_q   <= stage_start_d;
            current_stage_q <= current_stage_d;
            busy_q          <= busy_d;
            frame_count_q   <= frame_count_d;
            overrun_q       <= overrun_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    // A completed stage and an expired watchdog advance identically.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            SEQ_IDLE: begin
                if (startOfFrame && enable) begin
                    state_d = SEQ_START;
                    idx_d   = '0;
                end
            end
            SEQ_START: begin
                state_d = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (done_cur || wd_expired) begin
                    if (last_stage) begin
                        state_d = SEQ_IDLE;
                        idx_d   = '0;
                    end else begin
                        state_d = SEQ_START;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = SEQ_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        stage_start_d   = (state_d == SEQ_START) ? (NUM_STAGES'(1) << idx_d) : '0;
        current_stage_d = (state_d == SEQ_IDLE) ? '0 : idx_d;
        busy_d          = (state_d != SEQ_IDLE);
        frame_count_d   = frame_count_q + FRAME_CNT_WIDTH'(startOfFrame);
        overrun_d       = startOfFrame && (state_q != SEQ_IDLE);
        timeout_err_d   = (state_q == SEQ_WAIT) && !done_cur && wd_expired;
    end

    assign stage_start   = stage_start_q;
    assign current_stage = current_stage_q;
    assign busy          = busy_q;
    assign frame_count   = frame_count_q;
    assign overrun       = overrun_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// tb/tb_frame_update_sequencer.sv - scoreboard bench for frame_update_sequencer
module tb_frame_update_sequencer;

    localparam int N = 4;
    localparam int T = 8;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          startOfFrame = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  stage_done = '0;
    logic [N-1:0]  stage_start;
    logic [1:0]    current_stage;
    logic          busy;
    logic [15:0]   frame_count;
    logic          overrun;
    logic          timeout_err;

    frame_update_sequencer #(
        .NUM_STAGES      (N),
        .TIMEOUT_CYCLES  (T),
        .FRAME_CNT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .enable        (enable),
        .stage_done    (stage_done),
        .stage_start   (stage_start),
        .current_stage (current_stage),
        .busy          (busy),
        .frame_count   (frame_count),
        .overrun       (overrun),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int cyc;
        int val;
    } ev_t;

    ev_t q_st[$];
    ev_t q_to[$];
    ev_t q_ov[$];
    ev_t q_bf[$];

    // lat[k]: cycles from strobe k to its done pulse; 0 means the stage never answers
    int           lat[N];
    int           st_cyc[N];
    logic [N-1:0] hold_mask = '0;
    bit           glitch = 1'b0;
    bit           noise_en = 1'b0;
    int           lo = 0;
    int           hi = 0;
    int           fc_model = 0;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predict a whole pass from the latency table: each stage takes min(lat, T) wait cycles.
    task automatic launch(input int c);
        int s;
        int eff;
        s = c + 1;
        for (int k = 0; k < N; k++) begin
            q_st.push_back('{cyc: s, val: k});
            st_cyc[k] = s;
            if (lat[k] == 0 || lat[k] > T) begin
                eff = T;
                q_to.push_back('{cyc: s + T + 1, val: k});
            end else begin
                eff = lat[k];
            end
            s = s + eff + 1;
        end
        q_bf.push_back('{cyc: s, val: 0});
        lo = c + 1;
        hi = s;
    endtask

    task automatic sof();
        int c;
        c = cyc;
        startOfFrame = 1'b1;
        fc_model++;
        if (c >= lo && c < hi) begin
            q_ov.push_back('{cyc: c + 1, val: 0});
        end else if (enable) begin
            launch(c);
        end
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (cyc <= hi + 1 && g < 1000) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic responder();
        logic [N-1:0] d;
        int pend_k;
        int pend_at;
        bit pend_v;
        pend_v = 1'b0;
        pend_k = 0;
        pend_at = 0;
        forever begin
            @(negedge clk);
            d = hold_mask;
            if (!resetN) begin
                pend_v = 1'b0;
                d = '0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (stage_start[k]) begin
                        pend_k  = k;
                        pend_v  = 1'b1;
                        pend_at = (lat[k] == 0) ? -1 : cyc + lat[k];
                        if (glitch) d[k] = 1'b1;
                    end
                end
                if (pend_v && noise_en) begin
                    d = d | (N'($urandom) & ~(N'(1) << pend_k));
                end
                if (pend_v && pend_at == cyc) begin
                    d[pend_k] = 1'b1;
                    pend_v = 1'b0;
                end
            end
            stage_done = d;
        end
    endtask

    task automatic monitor();
        bit  prev_busy;
        ev_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                prev_busy = 1'b0;
            end else begin
                if (stage_start != '0) begin
                    if (q_st.size() == 0) begin
                        chk("strobe_unexpected", int'(stage_start), 0);
                    end else begin
                        e = q_st.pop_front();
                        chk("strobe_cycle", cyc, e.cyc);
                        chk("strobe_onehot", int'(stage_start), 1 << e.val);
                        chk("strobe_cur_stage", int'(current_stage), e.val);
                    end
                end
                if (timeout_err) begin
                    if (q_to.size() == 0) begin
                        chk("timeout_unexpected", 1, 0);
                    end else begin
                        e = q_to.pop_front();
                        chk("timeout_cycle", cyc, e.cyc);
                    end
                end
                if (overrun) begin
                    if (q_ov.size() == 0) begin
                        chk("overrun_unexpected", 1, 0);
                    end else begin
                        e = q_ov.pop_front();
                        chk("overrun_cycle", cyc, e.cyc);
                    end
                end
                if (prev_busy && !busy) begin
                    if (q_bf.size() == 0) begin
                        chk("busy_fall_unexpected", 1, 0);
                    end else begin
                        e = q_bf.pop_front();
                        chk("busy_fall_cycle", cyc, e.cyc);
                        chk("idle_cur_stage", int'(current_stage), 0);
                    end
                end
                prev_busy = busy;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stage_start"}, int'(stage_start), 0);
        chk({tag, "_cur_stage"}, int'(current_stage), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_frame_count"}, int'(frame_count), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_timeout"}, int'(timeout_err), 0);
    endtask

    initial begin
        fork
            monitor();
            responder();
        join_none

        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        // nominal pass: every stage answers 3 cycles after its strobe
        enable = 1'b1;
        lat = '{3, 3, 3, 3};
        sof();
        wait_idle();
        chk("fc_nominal", int'(frame_count), 1);

        // stage 2 never answers
        lat = '{2, 2, 0, 1};
        sof();
        wait_idle();

        // second frame lands in the wait of stage 1
        lat = '{2, 6, 2, 2};
        sof();
        while (cyc < st_cyc[1] + 2) @(negedge clk);
        sof();
        wait_idle();
        chk("fc_overrun", int'(frame_count), fc_model);

        // disabled: frames are counted but start nothing
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sof();
            repeat (4) @(negedge clk);
        end
        chk("fc_disabled", int'(frame_count), fc_model);
        chk("busy_disabled", int'(busy), 0);

        // done held high on stage 3 plus done pulses during START; enable dropped mid-pass
        enable = 1'b1;
        hold_mask = 4'b1000;
        glitch = 1'b1;
        lat = '{2, 1, 3, 1};
        sof();
        enable = 1'b0;
        wait_idle();
        hold_mask = '0;
        glitch = 1'b0;
        enable = 1'b1;

        // exact-boundary latency: done on the expiry cycle wins
        lat = '{8, 9, 1, 8};
        sof();
        wait_idle();

        // asynchronous reset in the wait of stage 2
        lat = '{2, 2, 0, 2};
        sof();
        while (cyc < st_cyc[2] + 3) @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        chk_zero("midreset");
        q_st.delete();
        q_to.delete();
        q_ov.delete();
        q_bf.delete();
        lo = 0;
        hi = 0;
        fc_model = 0;
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        chk("fc_after_reset", int'(frame_count), 0);
        lat = '{3, 3, 3, 3};
        sof();
        wait_idle();

        // randomized frames, latencies, noise and enable
        for (int it = 0; it < 40; it++) begin
            if (cyc >= hi) begin
                for (int k = 0; k < N; k++) lat[k] = $urandom_range(0, 9);
                noise_en = ($urandom_range(0, 1) == 1);
                enable = ($urandom_range(0, 4) != 0);
            end
            sof();
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_idle();
        noise_en = 1'b0;
        repeat (2) @(negedge clk);

        chk("fc_final", int'(frame_count), fc_model & 16'hffff);
        chk("busy_final", int'(busy), 0);
        chk("strobes_missing", q_st.size(), 0);
        chk("timeouts_missing", q_to.size(), 0);
        chk("overruns_missing", q_ov.size(), 0);
        chk("busy_falls_missing", q_bf.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
